// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input round-robin stream multiplexer with packet locking.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready (N channels);
//        out_data/out_last/out_sel/out_valid (registered), out_ready.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    // Arbiter state
    logic            locked;
    logic            locked_n;
    logic [SELW-1:0] lock_ch;
    logic [SELW-1:0] lock_ch_n;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_n;

    // Grant path
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            has_grant;
    logic [SELW-1:0] g;
    logic            load;
    logic            take;
    logic [WIDTH-1:0] sel_data;
    logic            sel_last;

    assign load = !out_valid || out_ready;
    assign take = load && has_grant && !rst;

    // Round-robin search: walk from the farthest offset down so the
    // channel closest to ptr is the last (winning) assignment.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (in_valid[idx]) begin
                rr_found = 1'b1;
                rr_idx   = SELW'(idx);
            end
        end
    end

    // A locked channel is the only candidate, even while it is idle.
    always_comb begin
        if (locked) begin
            g         = lock_ch;
            has_grant = in_valid[lock_ch];
        end else begin
            g         = rr_idx;
            has_grant = rr_found;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
        sel_last = in_last[g];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            locked  <= locked_n;
            lock_ch <= lock_ch_n;
            ptr     <= ptr_n;
        end
    end

    // FSM: next state
    always_comb begin
        locked_n  = locked;
        lock_ch_n = lock_ch;
        ptr_n     = ptr;
        if (take) begin
            if (sel_last) begin
                locked_n = 1'b0;
                if (g == SELW'(N - 1)) begin
                    ptr_n = '0;
                end else begin
                    ptr_n = g + SELW'(1);
                end
            end else begin
                locked_n  = 1'b1;
                lock_ch_n = g;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[g] = 1'b1;
        end
    end

    // Registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= g;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table-driven bench for stream_mux_rr (N=4, WIDTH=8).
// Ports: none; drives the DUT per cycle and checks in_ready and the output register.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [1:0]  e_os;
    } vec_t;

    vec_t vec[$];

    task automatic v(input logic r, input logic [3:0] vl, input logic [3:0] ls,
                     input logic [31:0] d, input logic ordy,
                     input logic [3:0] erdy, input logic eov,
                     input logic [7:0] eod, input logic eol,
                     input logic [1:0] eos);
        vec_t t;
        t.rst = r; t.vld = vl; t.lst = ls; t.dat = d; t.ordy = ordy;
        t.e_rdy = erdy; t.e_ov = eov; t.e_od = eod; t.e_ol = eol; t.e_os = eos;
        vec.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'h0;
        in_last   = 4'h0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset with everything requesting
        v(1, 4'hF, 4'hF, 32'h13121110, 1, 4'h0, 0, 8'h00, 0, 0);
        v(1, 4'hF, 4'hF, 32'h13121110, 1, 4'h0, 0, 8'h00, 0, 0);
        // round-robin wrap of single-beat packets
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h1, 1, 8'h10, 1, 0);
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h2, 1, 8'h11, 1, 1);
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h4, 1, 8'h12, 1, 2);
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h8, 1, 8'h13, 1, 3);
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h1, 1, 8'h10, 1, 0);
        v(0, 4'hF, 4'hF, 32'h13121110, 1, 4'h2, 1, 8'h11, 1, 1);
        // ptr=2, only ch3 requests -> ptr wraps to 0
        v(0, 4'h8, 4'hF, 32'h13121110, 1, 4'h8, 1, 8'h13, 1, 3);
        v(0, 4'h0, 4'hF, 32'h13121110, 1, 4'h0, 0, 8'h13, 1, 3);
        // packet lock on ch1, ch2 waiting
        v(0, 4'h2, 4'h0, 32'h0000A100, 1, 4'h2, 1, 8'hA1, 0, 1);
        v(0, 4'h6, 4'h4, 32'h0022A200, 1, 4'h2, 1, 8'hA2, 0, 1);
        v(0, 4'h6, 4'h6, 32'h0022A300, 1, 4'h2, 1, 8'hA3, 1, 1);
        v(0, 4'hD, 4'hF, 32'h23220020, 1, 4'h4, 1, 8'h22, 1, 2);
        v(0, 4'h9, 4'hF, 32'h23000020, 1, 4'h8, 1, 8'h23, 1, 3);
        v(0, 4'h0, 4'hF, 32'h00000000, 1, 4'h0, 0, 8'h23, 1, 3);
        // lock stall: ch3 idles mid-packet, ch0 must wait
        v(0, 4'h8, 4'h0, 32'h31000000, 1, 4'h8, 1, 8'h31, 0, 3);
        v(0, 4'h1, 4'hF, 32'h00000020, 1, 4'h0, 0, 8'h31, 0, 3);
        v(0, 4'h1, 4'hF, 32'h00000020, 1, 4'h0, 0, 8'h31, 0, 3);
        v(0, 4'h1, 4'hF, 32'h00000020, 1, 4'h0, 0, 8'h31, 0, 3);
        v(0, 4'h9, 4'hF, 32'h32000020, 1, 4'h8, 1, 8'h32, 1, 3);
        v(0, 4'h1, 4'hF, 32'h00000020, 1, 4'h1, 1, 8'h20, 1, 0);
        // backpressure on beat AA
        v(0, 4'h2, 4'hF, 32'h0000AA00, 1, 4'h2, 1, 8'hAA, 1, 1);
        v(0, 4'h4, 4'hF, 32'h00BB0000, 0, 4'h0, 1, 8'hAA, 1, 1);
        v(0, 4'h4, 4'hF, 32'h00BB0000, 0, 4'h0, 1, 8'hAA, 1, 1);
        v(0, 4'h4, 4'hF, 32'h00BB0000, 0, 4'h0, 1, 8'hAA, 1, 1);
        v(0, 4'h4, 4'hF, 32'h00BB0000, 0, 4'h0, 1, 8'hAA, 1, 1);
        v(0, 4'h4, 4'hF, 32'h00BB0000, 1, 4'h4, 1, 8'hBB, 1, 2);
        v(0, 4'h0, 4'hF, 32'h00000000, 1, 4'h0, 0, 8'hBB, 1, 2);
        // reset while LOCKED(2)
        v(0, 4'h4, 4'h0, 32'h00C10000, 1, 4'h4, 1, 8'hC1, 0, 2);
        v(1, 4'h5, 4'h1, 32'h00C20020, 1, 4'h0, 0, 8'h00, 0, 0);
        v(0, 4'h5, 4'h1, 32'h00C20020, 1, 4'h1, 1, 8'h20, 1, 0);

        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            rst       = vec[i].rst;
            in_valid  = vec[i].vld;
            in_last   = vec[i].lst;
            in_data   = vec[i].dat;
            out_ready = vec[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vec[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vec[i].e_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vec[i].e_od));
            chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(vec[i].e_ol));
            chk($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(vec[i].e_os));
        end

        // empty output register accepts even with out_ready low
        @(negedge clk);
        in_valid  = 4'h0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid  = 4'h2;
        in_last   = 4'h2;
        in_data   = 32'h00005A00;
        out_ready = 1'b0;
        #1;
        chk("empty load in_ready", 32'(in_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("empty load out_data", 32'(out_data), 32'h5A);
        chk("empty load out_sel", 32'(out_sel), 32'd1);
        @(negedge clk);
        in_valid = 4'h0;
        #1;
        chk("full stall in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (out_valid && n < 4) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("drain within bound", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
